reset_shutdown_seq: RTL

Run-time soft-reset sequencer, the tear-down counterpart of the power-up reset delay chain.
- On a soft-reset request it asks downstream logic to quiesce, then asserts the three staged reset domains in reverse order (2, then 1, then 0).
- It holds them, then releases them in forward order (0, then 1, then 2).
- Sits between the control/MIDI register block and the synthesizer voice/DSP/output domains.

---
 rtl/reset_shutdown_seq.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/reset_shutdown_seq.sv
// Soft-reset sequencer: quiesce downstream, assert reset domains 2->1->0, hold, release 0->1->2.
// Optional status ports (oBUSY, oTIMEOUT) are enabled by defining RST_SEQ_STATUS_EN.
module reset_shutdown_seq #(
  parameter int GAP         = 16,
  parameter int HOLD_CYCLES = 1024,
  parameter int TIMEOUT     = 4096,
  parameter int CW          = 24
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iREQ,
  input  logic       iQUIET,
  output logic       oQREQ,
  output logic       oRST_0,
  output logic       oRST_1,
  output logic       oRST_2,
`ifdef RST_SEQ_STATUS_EN
  output logic       oBUSY,
  output logic       oTIMEOUT,
`endif
  output logic [2:0] oDBG_STATE
);

  // Handshake: iREQ is a level sampled only in RUN; oQREQ stays high from the
  // request edge until domain 0 enters reset; iQUIET is only looked at in DRAIN.
  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_DRAIN = 3'd1,
    S_GAP2  = 3'd2,
    S_GAP1  = 3'd3,
    S_HOLD  = 3'd4,
    S_REL0  = 3'd5,
    S_REL1  = 3'd6
  } state_t;

  localparam logic [CW-1:0] L_GAP  = CW'(GAP - 1);
  localparam logic [CW-1:0] L_HOLD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] L_TO   = CW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cont;
  logic [CW-1:0] w_cont_nxt;
  logic          r_qreq;
  logic          w_qreq_nxt;
  logic [2:0]    r_rst;
  logic [2:0]    w_rst_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_qreq_nxt  = r_qreq;
    w_rst_nxt   = r_rst;
    case (r_state)
      S_RUN: begin
        if (iREQ) begin
          w_state_nxt = S_DRAIN;
          w_qreq_nxt  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (iQUIET || (r_cont == L_TO)) begin
          w_state_nxt  = S_GAP2;
          w_rst_nxt[2] = 1'b0;
        end
      end
      S_GAP2: begin
        if (r_cont == L_GAP) begin
          w_state_nxt  = S_GAP1;
          w_rst_nxt[1] = 1'b0;
        end
      end
      S_GAP1: begin
        if (r_cont == L_GAP) begin
          w_state_nxt  = S_HOLD;
          w_rst_nxt[0] = 1'b0;
          w_qreq_nxt   = 1'b0;
        end
      end
      S_HOLD: begin
        if (r_cont == L_HOLD) begin
          w_state_nxt  = S_REL0;
          w_rst_nxt[0] = 1'b1;
        end
      end
      S_REL0: begin
        if (r_cont == L_GAP) begin
          w_state_nxt  = S_REL1;
          w_rst_nxt[1] = 1'b1;
        end
      end
      S_REL1: begin
        if (r_cont == L_GAP) begin
          w_state_nxt  = S_RUN;
          w_rst_nxt[2] = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_HOLD;
        w_rst_nxt   = 3'b000;
        w_qreq_nxt  = 1'b0;
      end
    endcase

    // The counter restarts on every transition and idles at zero in RUN.
    if (w_state_nxt != r_state) begin
      w_cont_nxt = '0;
    end else if (r_state == S_RUN) begin
      w_cont_nxt = '0;
    end else begin
      w_cont_nxt = r_cont + 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= S_HOLD;
      r_cont  <= '0;
      r_qreq  <= 1'b0;
      r_rst   <= 3'b000;
    end else begin
      r_state <= w_state_nxt;
      r_cont  <= w_cont_nxt;
      r_qreq  <= w_qreq_nxt;
      r_rst   <= w_rst_nxt;
    end
  end

`ifdef RST_SEQ_STATUS_EN
  logic r_busy;
  logic r_timeout;
  logic w_to_evt;

  // DRAIN leaving on the counter alone means downstream never acknowledged.
  assign w_to_evt = (r_state == S_DRAIN) && !iQUIET && (r_cont == L_TO);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_busy    <= 1'b1;
      r_timeout <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_RUN);
      if (w_to_evt) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign oBUSY    = r_busy;
  assign oTIMEOUT = r_timeout;
`endif

  assign oQREQ      = r_qreq;
  assign oRST_0     = r_rst[0];
  assign oRST_1     = r_rst[1];
  assign oRST_2     = r_rst[2];
  assign oDBG_STATE = r_state;

endmodule
